datapath_mc: RTL and testbench
==============================

Name: datapath_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle processor datapath.
- Contains a register file, an ALU, an immediate/register operand mux and a load/store path.
- Accepts one command per start_i pulse, then sequences EXEC, an optional memory phase with a held request/ack handshake and ack timeout, and WB.
- Reports completion and error status to the controller.

Parameters:
- XLEN, 32: datapath and register width.
- NREG, 32: number of registers; RAW = $clog2(NREG) is the register-number width.
- ACK_TIMEOUT, 16: maximum memory-phase cycles without mem_ack_i before abort; must be ≥ 1.
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  command strobe; sampled only in IDLE.
- read_reg_num1  in  RAW  rs1.
- read_reg_num2  in  RAW  rs2.
- write_reg  in  RAW  rd.
- alu_control  in  4  ALU operation code.
- regwrite  in  1  write rd in WB.
- alu_src_b_i  in  1  1 selects immediate as operand B, 0 selects rs2.
- immediate_value_i  in  XLEN  immediate operand.
- mem_read_i  in  1  command is a load.
- mem_write_i  in  1  command is a store.
- mem_to_reg_i  in  1  write-back source is load data.
- mem_rdata_i  in  XLEN  load data, valid with mem_ack_i.
- mem_ack_i  in  1  memory acknowledge.
- mem_addr_o  out  XLEN  memory address (registered ALU result).
- mem_wdata_o  out  XLEN  store data (registered rs2).
- mem_re_o  out  1  read request.
- mem_we_o  out  1  write request.
- zero_flag  out  1  registered (ALU result == 0).
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; 1 means timeout or illegal command.

Behaviour:
- Reset (asynchronous): state IDLE; all registers, command latches and the timeout counter cleared. All outputs are 0 during and after reset. Reset asserted mid-memory phase drops mem_re_o/mem_we_o immediately, with no write-back.
- IDLE: start_i=1 latches every command input (register numbers, control bits, immediate), then goes to EXEC. start_i is ignored in every other state.
- EXEC (1 cycle): read rs1/rs2 using the latched numbers and compute the ALU result. Register alu_result, rs2 data and zero_flag; zero_flag holds until the next EXEC.
  - mem_read and mem_write both set: illegal; go to WB with the error flag set and no write.
  - Exactly one of them set: go to MEM and clear the timeout counter.
  - Neither set: go to WB.
- MEM:
  - mem_re_o or mem_we_o is held high, with mem_addr_o and mem_wdata_o stable, until the cycle in which mem_ack_i=1.
  - On ack: a load captures mem_rdata_i into the load register; go to WB. The request deasserts on the next cycle.
  - The counter increments each MEM cycle without ack. After ACK_TIMEOUT such cycles, drop the request, set the error flag and go to WB.
  - An ack in the final allowed cycle counts as success.
- WB (1 cycle): done_o=1 and err_o reflects the error flag.
  - The register file writes when regwrite=1 and err=0. Data is the load register if mem_to_reg, otherwise the ALU result.
  - The write is visible to reads from the next cycle.
  - Next state is IDLE.
- Latency from the start_i cycle T:
  - ALU-only command: done at T+2.
  - Memory command acked in its k-th MEM cycle: done at T+2+k.
  - Back-to-back start_i is accepted at T+3.
- ALU (XLEN bits, wrap-around arithmetic):
  - 0 AND, 1 OR, 2 ADD, 4 XOR, 6 SUB, 7 SLT (signed, result 0 or 1), 8 SLL, 9 SRL.
  - Shift amount is operand B[$clog2(XLEN)-1:0].
  - Other codes yield 0.
- Stray mem_ack_i outside MEM is ignored.
- Register file: two combinational read ports, one synchronous write port; contents cleared on reset.

Decomposition:
- Shared package datapath_pkg:
  - ALU opcode localparams.
  - State encoding (IDLE, EXEC, MEM, WB).
  - Default XLEN and NREG.
- One sub-module, reg_file_p, parametrised on XLEN, NREG and ZERO_REG.
- The ALU stays inline as a case statement.

Test Plan:
- Reset, then ADD r3 = r1 + r2 with r1=5, r2=7 preloaded: done_o at T+2, err_o=0, r3 reads 12, zero_flag=0.
- SUB r4 = r1 - r1, alu_src_b_i=0: zero_flag=1.
- SLT of 0xFFFFFFFF vs 1 gives 1.
- ADD of 0xFFFFFFFF + 1 with immediate gives 0 (wrap-around).
- Load with addr = r1 + imm 0x10, ack on the 3rd MEM cycle with rdata 0xDEADBEEF: mem_re_o high for exactly 3 cycles, mem_addr_o stable at 0x15, rd = 0xDEADBEEF, done at T+5.
- Store with no ack (ACK_TIMEOUT=16): mem_we_o high for exactly 16 cycles then low, done_o with err_o=1, no register changes. Then repeat with ack in cycle 16: err_o=0.
- Command with both mem_read and mem_write set: no mem_re_o/mem_we_o, done_o with err_o=1, rd unchanged.
- Write to r0 with ZERO_REG=1 reads back 0.
- start_i pulsed while busy is ignored.
- Reset asserted mid-MEM: mem_re_o low in the same cycle, busy_o=0, no done_o.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath:
// ALU opcodes, FSM state encoding and default widths.
package datapath_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

endpackage

// File: rtl/datapath_mc_if.sv
// Memory request/acknowledge bus between the
// datapath (master) and the memory (slave).
interface datapath_mc_if
    import datapath_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);

    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_re_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_ack_i;

    modport master (
        output mem_addr_o,
        output mem_wdata_o,
        output mem_re_o,
        output mem_we_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_re_o,
        input  mem_we_o,
        output mem_rdata_i,
        output mem_ack_i
    );

endinterface

// File: rtl/datapath_mc_reg_file.sv
// Register file: two combinational read ports,
// one synchronous write port, cleared on reset.
module reg_file_p
    import datapath_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int ZERO_REG = 1,
    localparam int RAW     = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RAW-1:0]  ra1_i,
    input  logic [RAW-1:0]  ra2_i,
    input  logic [RAW-1:0]  wa_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_ok;

    assign wr_ok = we_i && !((ZERO_REG != 0) && (wa_i == '0));

    // Storage: clear on reset, write one register per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = ((ZERO_REG != 0) && (ra1_i == '0)) ? '0 : regs_q[ra1_i];
    assign rd2_o = ((ZERO_REG != 0) && (ra2_i == '0)) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: IDLE -> EXEC -> (MEM) -> WB,
// with held memory handshake and ack timeout.
module datapath_mc
    import datapath_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int NREG        = DEF_NREG,
    parameter int ACK_TIMEOUT = 16,
    parameter int ZERO_REG    = 1,
    localparam int RAW        = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [RAW-1:0]  read_reg_num1,
    input  logic [RAW-1:0]  read_reg_num2,
    input  logic [RAW-1:0]  write_reg,
    input  logic [3:0]      alu_control,
    input  logic            regwrite,
    input  logic            alu_src_b_i,
    input  logic [XLEN-1:0] immediate_value_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    datapath_mc_if.master   mem,
    output logic            zero_flag,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    state_t          state_q;
    logic [RAW-1:0]  rs1_q;
    logic [RAW-1:0]  rs2_q;
    logic [RAW-1:0]  rd_q;
    logic [3:0]      op_q;
    logic            rw_q;
    logic            bsel_q;
    logic [XLEN-1:0] imm_q;
    logic            mr_q;
    logic            mw_q;
    logic            m2r_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] ld_q;
    logic            zero_q;
    logic            re_q;
    logic            we_q;
    logic            done_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_d;
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;

    assign rf_we = (state_q == S_WB) && rw_q && !err_q;
    assign rf_wd = m2r_q ? ld_q : alu_q;

    reg_file_p #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk_i (clock),
        .rst_i (reset),
        .ra1_i (rs1_q),
        .ra2_i (rs2_q),
        .wa_i  (rd_q),
        .we_i  (rf_we),
        .wd_i  (rf_wd),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign op_b = bsel_q ? imm_q : rd2;

    // ALU on the latched command; unknown opcodes give zero.
    always_comb begin
        alu_d = '0;
        case (op_q)
            ALU_AND: alu_d = rd1 & op_b;
            ALU_OR:  alu_d = rd1 | op_b;
            ALU_ADD: alu_d = rd1 + op_b;
            ALU_XOR: alu_d = rd1 ^ op_b;
            ALU_SUB: alu_d = rd1 - op_b;
            ALU_SLT: alu_d = {{(XLEN-1){1'b0}},
                              ($signed(rd1) < $signed(op_b))};
            ALU_SLL: alu_d = rd1 << op_b[SW-1:0];
            ALU_SRL: alu_d = rd1 >> op_b[SW-1:0];
            default: alu_d = '0;
        endcase
    end

    // Sequencer with registered status and memory request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            rw_q    <= 1'b0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            zero_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rs1_q   <= read_reg_num1;
                        rs2_q   <= read_reg_num2;
                        rd_q    <= write_reg;
                        op_q    <= alu_control;
                        rw_q    <= regwrite;
                        bsel_q  <= alu_src_b_i;
                        imm_q   <= immediate_value_i;
                        mr_q    <= mem_read_i;
                        mw_q    <= mem_write_i;
                        m2r_q   <= mem_to_reg_i;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q   <= alu_d;
                    wdata_q <= rd2;
                    zero_q  <= (alu_d == '0);
                    if (mr_q && mw_q) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_WB;
                    end else if (mr_q || mw_q) begin
                        cnt_q   <= '0;
                        re_q    <= mr_q;
                        we_q    <= mw_q;
                        state_q <= S_MEM;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ack_i) begin
                        if (mr_q) begin
                            ld_q <= mem.mem_rdata_i;
                        end
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end else if (cnt_q == TO_LAST) begin
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_WB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_addr_o  = alu_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_re_o    = re_q;
    assign mem.mem_we_o    = we_q;
    assign zero_flag       = zero_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Randomized bench for datapath_mc against a
// command-level reference model.
module tb_datapath_mc;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic [4:0]  read_reg_num1;
    logic [4:0]  read_reg_num2;
    logic [4:0]  write_reg;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic        alu_src_b_i;
    logic [31:0] immediate_value_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        mem_to_reg_i;
    logic        zero_flag;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    datapath_mc_if #(.XLEN(32)) mif ();

    datapath_mc #(
        .XLEN        (32),
        .NREG        (32),
        .ACK_TIMEOUT (TO),
        .ZERO_REG    (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start_i           (start_i),
        .read_reg_num1     (read_reg_num1),
        .read_reg_num2     (read_reg_num2),
        .write_reg         (write_reg),
        .alu_control       (alu_control),
        .regwrite          (regwrite),
        .alu_src_b_i       (alu_src_b_i),
        .immediate_value_i (immediate_value_i),
        .mem_read_i        (mem_read_i),
        .mem_write_i       (mem_write_i),
        .mem_to_reg_i      (mem_to_reg_i),
        .mem               (mif),
        .zero_flag         (zero_flag),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mregs [32];
    logic [31:0] ld_m;
    logic [31:0] last_addr;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a + b;
            4: return a ^ b;
            6: return a - b;
            7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8: return a << b[4:0];
            9: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic scramble();
        read_reg_num1     = 5'($urandom);
        read_reg_num2     = 5'($urandom);
        write_reg         = 5'($urandom);
        alu_control       = 4'($urandom);
        regwrite          = 1'($urandom);
        alu_src_b_i       = 1'($urandom);
        immediate_value_i = $urandom;
        mem_read_i        = 1'($urandom);
        mem_write_i       = 1'($urandom);
        mem_to_reg_i      = 1'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        ld_m = 32'd0;
    endtask

    // One command; ack_at = MEM cycle carrying the ack (0 = none).
    task automatic do_cmd(input int rs1, input int rs2, input int rd,
                          input int op, input int rw, input int bsel,
                          input logic [31:0] imm, input int mr,
                          input int mw, input int m2r, input int ack_at,
                          input logic [31:0] rdat);
        logic [31:0] a, b, res, wv;
        int  cyc, reqc, exp_lat, exp_req;
        bit  done, gerr, ill, ismem, ok, exp_err, wrong;
        a = mregs[rs1];
        wv = mregs[rs2];
        b = bsel ? imm : wv;
        res = ref_alu(op, a, b);
        ill = (mr != 0) && (mw != 0);
        ismem = ((mr != 0) || (mw != 0)) && !ill;
        ok = ismem && ack_at >= 1 && ack_at <= TO;
        exp_err = ill || (ismem && !ok);
        exp_req = ismem ? (ok ? ack_at : TO) : 0;
        exp_lat = 2 + exp_req;
        @(negedge clock);
        read_reg_num1     = 5'(rs1);
        read_reg_num2     = 5'(rs2);
        write_reg         = 5'(rd);
        alu_control       = 4'(op);
        regwrite          = 1'(rw);
        alu_src_b_i       = 1'(bsel);
        immediate_value_i = imm;
        mem_read_i        = 1'(mr);
        mem_write_i       = 1'(mw);
        mem_to_reg_i      = 1'(m2r);
        start_i           = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        scramble();
        cyc = 1; reqc = 0; done = 0; gerr = 0; wrong = 0;
        while (!done && cyc < 64) begin
            mif.mem_ack_i   = 1'b0;
            mif.mem_rdata_i = $urandom;
            if (cyc == 1) begin
                mif.mem_ack_i = 1'($urandom);
                start_i       = 1'($urandom);
            end else begin
                start_i = 1'b0;
            end
            if (mif.mem_re_o || mif.mem_we_o) begin
                reqc++;
                if (mif.mem_re_o !== 1'(mr) || mif.mem_we_o !== 1'(mw) ||
                    mif.mem_addr_o !== res || mif.mem_wdata_o !== wv)
                    wrong = 1;
                if (reqc == ack_at) begin
                    mif.mem_ack_i   = 1'b1;
                    mif.mem_rdata_i = rdat;
                end
            end
            if (done_o) begin
                done = 1;
                gerr = err_o;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        mif.mem_ack_i = 1'b0;
        chk("latency", cyc, exp_lat);
        chk("err", gerr, exp_err);
        chk("req_cycles", reqc, exp_req);
        chk("req_bus", wrong, 0);
        chk("req_off", {mif.mem_re_o, mif.mem_we_o}, 0);
        chk("zero_flag", zero_flag, (res == 32'd0));
        chk("alu_addr", mif.mem_addr_o, res);
        chk("wdata", mif.mem_wdata_o, wv);
        last_addr = mif.mem_addr_o;
        last_err  = err_o;
        if (ismem && ok && mr != 0) ld_m = rdat;
        if (!exp_err && rw != 0 && rd != 0)
            mregs[rd] = (m2r != 0) ? ld_m : res;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        do_cmd(0, 0, r, 2, 1, 1, v, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic read_reg(input int r);
        do_cmd(r, 0, 0, 1, 0, 1, 32'd0, 0, 0, 0, 0, 32'd0);
    endtask

    int ops [10] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 15};

    initial begin
        start_i = 1'b0;
        scramble();
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = 32'd0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_req", {mif.mem_re_o, mif.mem_we_o}, 0);
        chk("rst_addr", mif.mem_addr_o, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_outs", {busy_o, done_o, err_o, zero_flag}, 0);

        set_reg(1, 32'd5);
        set_reg(2, 32'd7);
        do_cmd(1, 2, 3, 2, 1, 0, 32'd0, 0, 0, 0, 0, 32'd0);
        chk("add_zf", zero_flag, 0);
        read_reg(3);
        chk("r3_add", last_addr, 32'd12);
        do_cmd(1, 1, 4, 6, 1, 0, 32'd0, 0, 0, 0, 0, 32'd0);
        chk("sub_zf", zero_flag, 1);
        set_reg(5, 32'hFFFF_FFFF);
        set_reg(6, 32'd1);
        do_cmd(5, 6, 7, 7, 1, 0, 32'd0, 0, 0, 0, 0, 32'd0);
        read_reg(7);
        chk("slt_neg", last_addr, 32'd1);
        do_cmd(5, 0, 8, 2, 1, 1, 32'd1, 0, 0, 0, 0, 32'd0);
        chk("wrap_zf", zero_flag, 1);
        chk("wrap_res", last_addr, 32'd0);

        do_cmd(1, 2, 9, 2, 1, 1, 32'h10, 1, 0, 1, 3, 32'hDEAD_BEEF);
        chk("ld_addr", last_addr, 32'h15);
        read_reg(9);
        chk("ld_r9", last_addr, 32'hDEAD_BEEF);

        do_cmd(1, 2, 10, 2, 1, 1, 32'd0, 0, 1, 0, 0, 32'd0);
        chk("st_to_err", last_err, 1);
        read_reg(10);
        chk("st_to_r10", last_addr, 32'd0);
        do_cmd(1, 2, 10, 2, 0, 1, 32'd0, 0, 1, 0, TO, 32'd0);
        chk("st_last_ok", last_err, 0);

        do_cmd(1, 2, 3, 2, 1, 1, 32'd99, 1, 1, 0, 1, 32'd0);
        chk("illegal_err", last_err, 1);
        read_reg(3);
        chk("illegal_r3", last_addr, 32'd12);

        set_reg(0, 32'h1234);
        read_reg(0);
        chk("r0_zero", last_addr, 32'd0);

        for (int i = 1; i < 32; i++) set_reg(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            int sel, mr, mw;
            sel = $urandom_range(0, 9);
            mr = (sel == 6 || sel == 7 || sel == 9) ? 1 : 0;
            mw = (sel == 8 || sel == 9) ? 1 : 0;
            do_cmd($urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), ops[$urandom_range(0, 9)],
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                   mr, mw, $urandom_range(0, 1), $urandom_range(1, 20),
                   $urandom);
        end

        @(negedge clock);
        read_reg_num1 = 5'd1; alu_control = 4'd2; alu_src_b_i = 1'b1;
        mem_read_i = 1'b1; mem_write_i = 1'b0; regwrite = 1'b1;
        write_reg = 5'd3; mem_to_reg_i = 1'b1;
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_mem_req", mif.mem_re_o, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_re", mif.mem_re_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_done", done_o, 0);
        repeat (2) @(negedge clock);
        chk("rst_hold_done", done_o, 0);
        reset = 1'b0;
        model_reset();
        read_reg(3);
        chk("rst_r3", last_addr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
